// File: rtl/pirdsp_pkg.sv
// Shared constants for the PIR DSP slice: operating modes, SIMD lane geometry
// and the carry-pair bit layout used between neighbouring slices.
package pirdsp_pkg;

    localparam logic MODE_27X27 = 1'b0;
    localparam logic MODE_SIMD  = 1'b1;

    localparam int unsigned LANES   = 3;
    localparam int unsigned LANE_W  = 18;
    localparam int unsigned WIDTH   = LANES * LANE_W;
    localparam int unsigned CARRY_W = 2 * LANES;

    // Carry pair per lane: bit 2i is the W/X/Y chain, bit 2i+1 the Z chain.
    localparam int unsigned CARRY_WXY = 0;
    localparam int unsigned CARRY_Z   = 1;

    typedef struct packed {
        logic pd;
        logic pdb;
    } patdet_flags_t;

    function automatic int unsigned carry_idx(input int unsigned lane, input int unsigned chain);
        return 2 * lane + chain;
    endfunction

endpackage

// File: rtl/pirdsp_pattern_detect.sv
// Masked pattern compare for one SIMD lane; produces both the true and the
// complemented-value match so the top can derive overflow and underflow.
module pirdsp_pattern_detect #(
    parameter int unsigned LANE_W = 18
) (
    input  logic [LANE_W-1:0] value,
    input  logic [LANE_W-1:0] pattern,
    input  logic [LANE_W-1:0] mask,
    output logic              match_c,
    output logic              match_b_c
);

    // Mask bit set means the bit does not take part in the compare.
    assign match_c   = (((value ^ pattern) & ~mask) == '0);
    assign match_b_c = (((~value ^ pattern) & ~mask) == '0);

endmodule

// File: rtl/pirdsp_result_stage.sv
// P-register stage of the DSP slice: captures the ALU result and carries,
// registers pattern-detect flags and derives overflow/underflow from them.
module pirdsp_result_stage #(
    parameter int unsigned WIDTH            = 54,
    parameter int unsigned LANES            = 3,
    parameter int unsigned LANE_W           = 18,
    parameter int unsigned AUTORESET_PATDET = 0
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 CEP,
    input  logic                 RSTP,
    input  logic                 USE_SIMD,
    input  logic [WIDTH-1:0]     S,
    input  logic [2*LANES-1:0]   result_SIMD_carry_in,
    input  logic                 VALID_IN,
    input  logic [WIDTH-1:0]     PATTERN,
    input  logic [WIDTH-1:0]     MASK,
    output logic [WIDTH-1:0]     P,
    output logic [2*LANES-1:0]   result_SIMD_carry_out,
    output logic                 VALID_OUT,
    output logic                 PATTERNDETECT,
    output logic                 PATTERNBDETECT,
    output logic                 OVERFLOW,
    output logic                 UNDERFLOW
);
    import pirdsp_pkg::*;

    logic             ar_fire_c;
    logic [WIDTH-1:0] s_cap_c;
    logic [LANES-1:0] lane_pd_c;
    logic [LANES-1:0] lane_pdb_c;
    logic             pd_next_c;
    logic             pdb_next_c;
    logic             pd_past;
    logic             pdb_past;

    // A registered match clears P on the next enabled edge; CEP=0 defers it.
    assign ar_fire_c = (AUTORESET_PATDET != 0) && PATTERNDETECT && CEP;
    assign s_cap_c   = ar_fire_c ? '0 : S;

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        pirdsp_pattern_detect #(
            .LANE_W (LANE_W)
        ) u_pd (
            .value     (s_cap_c[i*LANE_W +: LANE_W]),
            .pattern   (PATTERN[i*LANE_W +: LANE_W]),
            .mask      (MASK[i*LANE_W +: LANE_W]),
            .match_c   (lane_pd_c[i]),
            .match_b_c (lane_pdb_c[i])
        );
    end

    assign pd_next_c  = &lane_pd_c;
    assign pdb_next_c = &lane_pdb_c;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            P                     <= '0;
            result_SIMD_carry_out <= '0;
            VALID_OUT             <= 1'b0;
            PATTERNDETECT         <= 1'b0;
            PATTERNBDETECT        <= 1'b0;
            pd_past               <= 1'b0;
            pdb_past              <= 1'b0;
        end else if (RSTP) begin
            P                     <= '0;
            result_SIMD_carry_out <= '0;
            VALID_OUT             <= 1'b0;
            PATTERNDETECT         <= 1'b0;
            PATTERNBDETECT        <= 1'b0;
            pd_past               <= 1'b0;
            pdb_past              <= 1'b0;
        end else if (CEP) begin
            P                     <= s_cap_c;
            result_SIMD_carry_out <= ar_fire_c ? '0 : result_SIMD_carry_in;
            VALID_OUT             <= ar_fire_c ? 1'b0 : VALID_IN;
            PATTERNDETECT         <= pd_next_c;
            PATTERNBDETECT        <= pdb_next_c;
            pd_past               <= PATTERNDETECT;
            pdb_past              <= PATTERNBDETECT;
        end
    end

    // Leaving the pattern window without landing on either match flags a wrap.
    assign OVERFLOW  = pd_past  & ~PATTERNDETECT & ~PATTERNBDETECT & (USE_SIMD != MODE_SIMD);
    assign UNDERFLOW = pdb_past & ~PATTERNDETECT & ~PATTERNBDETECT & (USE_SIMD != MODE_SIMD);

endmodule
